// File: rtl/bit_window_unpacker_if.sv
// ============================================================================
// Module   : bit_window_unpacker_if
// Brief    : Packed-word input and bit-window output handshakes of the unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_window_unpacker_if #(
  parameter int DATA_W = 8
);
  localparam int FILL_W = $clog2(2*DATA_W+1);
  localparam int LEN_W  = $clog2(DATA_W+1);

  logic [DATA_W-1:0] data_i;
  logic              last_i;
  logic              vld_i;
  logic              rdy_o;
  logic [DATA_W-1:0] window_o;
  logic [FILL_W-1:0] avail_o;
  logic              vld_o;
  logic              last_o;
  logic [LEN_W-1:0]  len_i;
  logic              rdy_i;

  modport slave (
    input  data_i, last_i, vld_i, len_i, rdy_i,
    output rdy_o, window_o, avail_o, vld_o, last_o
  );

  modport master (
    output data_i, last_i, vld_i, len_i, rdy_i,
    input  rdy_o, window_o, avail_o, vld_o, last_o
  );
endinterface

`default_nettype wire

// File: rtl/bit_window_unpacker.sv
// ============================================================================
// Module   : bit_window_unpacker
// Brief    : Presents the next DATA_W unconsumed bits of a packed word stream,
//            MSB-aligned; optional UNPACKER_UNDERRUN_CHK_EN adds sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_window_unpacker #(
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  bit_window_unpacker_if.slave  bus,
  input  logic                  flush_i,
  output logic                  idle_o
`ifdef UNPACKER_UNDERRUN_CHK_EN
  ,output logic                 err_o
`endif
);
  localparam int FILL_W = $clog2(2*DATA_W+1);
  localparam int BUF_W  = 2*DATA_W;
  localparam logic [FILL_W-1:0] C_DATA_W = FILL_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_READY   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;

  logic               consume;
  logic               accept;
  logic               rdy;
  logic [FILL_W-1:0]  len_ext;
  logic [FILL_W-1:0]  take;
  logic [FILL_W-1:0]  rem;

  always_comb begin
    len_ext = FILL_W'(bus.len_i);
    consume = vld_q && bus.rdy_i;
    take    = '0;
    if (consume) begin
      take = (len_ext > fill_q) ? fill_q : len_ext;
    end
    rem    = fill_q - take;
    // A word may land in the same cycle as a consume as long as it fits.
    rdy    = !flush_i && (state_q != ST_DRAIN) && (rem <= C_DATA_W);
    accept = bus.vld_i && rdy;

    buf_d   = buf_q << take;
    fill_d  = rem;
    state_d = state_q;
    if (accept) begin
      buf_d  = buf_d | ({bus.data_i, {DATA_W{1'b0}}} >> rem);
      fill_d = rem + C_DATA_W;
    end

    case (state_q)
      ST_EMPTY, ST_FILLING: begin
        if (accept) begin
          state_d = bus.last_i ? ST_DRAIN : ST_READY;
        end
      end
      ST_READY: begin
        if (accept) begin
          if (bus.last_i) begin
            state_d = ST_DRAIN;
          end
        end else if (fill_d == '0) begin
          state_d = ST_EMPTY;
        end else if (fill_d < C_DATA_W) begin
          state_d = ST_FILLING;
        end
      end
      ST_DRAIN: begin
        if (fill_d == '0) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush_i) begin
      buf_d   = '0;
      fill_d  = '0;
      state_d = ST_EMPTY;
    end

    vld_d  = (state_d == ST_READY) || (state_d == ST_DRAIN);
    last_d = (state_d == ST_DRAIN);
  end

`ifdef UNPACKER_UNDERRUN_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (consume && (len_ext > fill_q));
    if (flush_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      fill_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign bus.rdy_o    = rdy;
  assign bus.window_o = buf_q[BUF_W-1 -: DATA_W];
  assign bus.avail_o  = fill_q;
  assign bus.vld_o    = vld_q;
  assign bus.last_o   = last_q;
  assign idle_o       = (state_q == ST_EMPTY) && !bus.vld_i;

endmodule

`default_nettype wire

// File: tb/tb_bit_window_unpacker.sv
// ============================================================================
// Module   : tb_bit_window_unpacker
// Brief    : Scoreboard bench for bit_window_unpacker using a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_window_unpacker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic idle;
  logic err;

  always #5 clk = ~clk;

  bit_window_unpacker_if #(.DATA_W(8)) bus ();

  bit_window_unpacker #(.DATA_W(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .flush_i (flush),
    .idle_o  (idle)
`ifdef UNPACKER_UNDERRUN_CHK_EN
    ,.err_o  (err)
`endif
  );

`ifndef UNPACKER_UNDERRUN_CHK_EN
  assign err = 1'b0;
`endif

  typedef struct {
    logic [7:0] win;
    logic [4:0] avail;
    logic       vld;
    logic       last;
    logic       err;
  } exp_t;

  exp_t sb[$];
  bit   mq[$];
  bit   drained = 0;
  bit   err_m = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_window();
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < mq.size()) w[7-i] = mq[i];
    end
    return w;
  endfunction

  // Monitor: compares every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("mon window_o", bus.window_o, e.win);
        check("mon avail_o", bus.avail_o, e.avail);
        check("mon vld_o", bus.vld_o, e.vld);
        check("mon last_o", bus.last_o, e.last);
`ifdef UNPACKER_UNDERRUN_CHK_EN
        check("mon err_o", err, e.err);
`endif
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic ri, input int len, input logic fl);
    int   sz;
    int   take;
    logic vm;
    logic rexp;
    logic iexp;
    exp_t e;
    @(negedge clk);
    bus.vld_i  = v;
    bus.data_i = d;
    bus.last_i = l;
    bus.rdy_i  = ri;
    bus.len_i  = 4'(len);
    flush      = fl;
    #1;
    sz   = mq.size();
    vm   = drained ? (sz > 0) : (sz >= 8);
    take = (vm && ri) ? ((len < sz) ? len : sz) : 0;
    rexp = !fl && !drained && (sz - take <= 8);
    iexp = (sz == 0) && !v;
    check("rdy_o", bus.rdy_o, rexp);
    check("idle_o", idle, iexp);
    if (fl) begin
      mq.delete();
      drained = 0;
      err_m   = 0;
    end else begin
      if (vm && ri && len > sz) err_m = 1;
      for (int i = 0; i < take; i++) void'(mq.pop_front());
      if (v && rexp) begin
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        if (l) drained = 1;
      end
      if (mq.size() == 0) drained = 0;
    end
    e.win   = exp_window();
    e.avail = 5'(mq.size());
    e.vld   = drained ? (mq.size() > 0) : (mq.size() >= 8);
    e.last  = drained && (mq.size() > 0);
    e.err   = err_m;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.vld_i  = 1'b0;
    bus.data_i = '0;
    bus.last_i = 1'b0;
    bus.rdy_i  = 1'b0;
    bus.len_i  = '0;

    #12;
    check("reset rdy_o", bus.rdy_o, 1'b1);
    check("reset vld_o", bus.vld_o, 1'b0);
    check("reset avail_o", bus.avail_o, 5'd0);
    check("reset window_o", bus.window_o, 8'h00);
    check("reset idle_o", idle, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 0, 0);
    check("post-reset idle_o", idle, 1'b1);
    check("post-reset avail_o", bus.avail_o, 5'd0);

    // Two pushes without consumption, then a 3-bit consume.
    step(1, 8'hA5, 0, 0, 0, 0);
    check("push1 window_o", bus.window_o, 8'hA5);
    check("push1 avail_o", bus.avail_o, 5'd8);
    step(1, 8'h3C, 0, 0, 0, 0);
    check("push2 avail_o", bus.avail_o, 5'd16);
    check("push2 rdy_o", bus.rdy_o, 1'b0);
    step(0, 8'h00, 0, 1, 3, 0);
    check("consume3 window_o", bus.window_o, 8'h29);
    check("consume3 avail_o", bus.avail_o, 5'd13);

    // Flush with a word offered.
    step(1, 8'h77, 0, 0, 0, 1);
    check("flush avail_o", bus.avail_o, 5'd0);
    check("flush window_o", bus.window_o, 8'h00);
    check("flush vld_o", bus.vld_o, 1'b0);

    // Full-rate streaming.
    step(1, 8'h11, 0, 1, 8, 0);
    check("stream window 11", bus.window_o, 8'h11);
    step(1, 8'h22, 0, 1, 8, 0);
    check("stream window 22", bus.window_o, 8'h22);
    step(1, 8'h33, 0, 1, 8, 0);
    check("stream window 33", bus.window_o, 8'h33);
    step(0, 8'h00, 0, 1, 8, 0);
    check("stream drained avail_o", bus.avail_o, 5'd0);

    // Stream tail.
    step(1, 8'hF0, 1, 0, 0, 0);
    check("tail vld_o", bus.vld_o, 1'b1);
    check("tail last_o", bus.last_o, 1'b1);
    check("tail avail_o", bus.avail_o, 5'd8);
    check("tail rdy_o", bus.rdy_o, 1'b0);
    step(0, 8'h00, 0, 1, 4, 0);
    check("tail4 window_o", bus.window_o, 8'h00);
    check("tail4 avail_o", bus.avail_o, 5'd4);
    step(0, 8'h00, 0, 1, 4, 0);
    check("tail empty idle_o", idle, 1'b1);
    check("tail empty avail_o", bus.avail_o, 5'd0);

    // Over-consumption in the tail is clamped.
    step(1, 8'hF8, 1, 0, 0, 0);
    step(0, 8'h00, 0, 1, 3, 0);
    check("under avail 5", bus.avail_o, 5'd5);
    step(0, 8'h00, 0, 1, 7, 0);
    check("under avail 0", bus.avail_o, 5'd0);
`ifdef UNPACKER_UNDERRUN_CHK_EN
    check("under err_o set", err, 1'b1);
`endif
    step(1, 8'hAA, 0, 0, 0, 0);
`ifdef UNPACKER_UNDERRUN_CHK_EN
    check("under err_o sticky", err, 1'b1);
`endif
    step(0, 8'h00, 0, 0, 0, 1);
`ifdef UNPACKER_UNDERRUN_CHK_EN
    check("under err_o cleared", err, 1'b0);
`endif

    // Randomized traffic against the bit-queue model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0,
           ($urandom % 3) != 0, int'($urandom_range(0, 8)), ($urandom % 40) == 0);
    end

    // Asynchronous reset mid-stream.
    step(1, 8'h5A, 0, 0, 0, 0);
    @(negedge clk);
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b0;
    flush     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset avail_o", bus.avail_o, 5'd0);
    check("async reset vld_o", bus.vld_o, 1'b0);
    check("async reset window_o", bus.window_o, 8'h00);
    mq.delete();
    drained = 0;
    err_m   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hC3, 0, 0, 0, 0);
    check("after reset window_o", bus.window_o, 8'hC3);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
